fpu_dispatch: RTL
=================

Name: fpu_dispatch

Overview:
Core-side initiator for the single-operand and two-operand FPU units. Each unit has a valid-only interface: data and valid in, result data and valid out, fixed latency of at least 1 cycle, no ready signal. This block accepts one FPU instruction from the core and issues a single a_valid pulse to the selected unit. It waits for that unit's c_valid, captures the result, writes it back to the FP register file, and stalls the core via busy for the whole transaction.

Parameters:
NUM_UNITS, 4, number of attached FPU units; unit index equals req_op
OP_W, 3, width of req_op
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with the optional feature

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
req_valid  in  1  instruction request from core; sampled only when busy=0
req_op  in  OP_W  target unit index
req_a  in  32  operand A
req_b  in  32  operand B; ignored by single-operand units
req_rd  in  5  destination FP register
busy  out  1  core stall
unit_a_data  out  32  operand A broadcast to all units
unit_b_data  out  32  operand B broadcast to all units
unit_a_valid  out  NUM_UNITS  one-hot issue pulse
unit_c_data  in  32*NUM_UNITS  unit results; unit i occupies slice [32*i+31:32*i]
unit_c_valid  in  NUM_UNITS  unit result valids
wb_en  out  1  FP register write enable
wb_addr  out  5  write address
wb_data  out  32  write data
illegal_op  out  1  one-cycle pulse when req_op >= NUM_UNITS
timeout_err  out  1  one-cycle pulse on watchdog expiry; constant 0 without the feature

Behaviour:
- Reset: all outputs are registered and are 0 during reset (busy, unit_a_valid, operands, wb_*, illegal_op, timeout_err). The state is IDLE.
- Reset asserted mid-transaction aborts to IDLE with no writeback. A late c_valid arriving in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - busy=0.
  - On req_valid with req_op < NUM_UNITS: latch op, rd, req_a, req_b; go to ISSUE.
  - On req_valid with req_op >= NUM_UNITS: pulse illegal_op for one cycle, stay in IDLE, no writeback, busy stays 0.
- ISSUE:
  - unit_a_valid[op]=1 for exactly one cycle; all other bits are 0.
  - unit_a_data and unit_b_data hold the latched operands, stable from ISSUE through WB.
  - Go to WAIT.
- WAIT:
  - When unit_c_valid[op]=1, capture that unit's slice into the result register and go to WB.
  - c_valid from unselected units is ignored.
  - c_valid[op] asserted in the ISSUE cycle is ignored (stale).
- WB:
  - wb_en=1 for exactly one cycle, with wb_addr=latched rd and wb_data=result.
  - Go to IDLE.
- busy=1 in ISSUE, WAIT and WB. busy is also set in the cycle after a legal request is accepted.
- Latency for a unit of latency L (request sampled at edge 0):
  - unit_a_valid high in cycle 1
  - c_valid in cycle 1+L
  - wb_en high in cycle 2+L
  - busy low in cycle 3+L
- Example, negation unit with L=1: issue in cycle 1, writeback in cycle 3, next request accepted in cycle 4.
- req_valid while busy=1 has no effect; the core holds the request.

Optional Feature:
Macro FPU_DISPATCH_TIMEOUT_EN.
- With it:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without c_valid[op]: pulse timeout_err for one cycle, go to IDLE, no writeback.
  - A c_valid[op] in the same cycle as expiry wins: normal path to WB, no error.
- Without it:
  - WAIT lasts indefinitely.
  - timeout_err is tied to 0; the port and the parameter remain.

Decomposition:
- Package fpu_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, WB)
  - FPR_ADDR_W=5 and FP_W=32
  - unit index constants: UNIT_NEG=0, UNIT_ABS=1, UNIT_ADD=2, UNIT_MUL=3
- One sub-module, fpu_dispatch_timer: holds the watchdog counter, instantiated only under FPU_DISPATCH_TIMEOUT_EN.

Test Plan:
1. Request op=0 (neg), a=0x3F800000, rd=7, with a 1-cycle neg model -> unit_a_valid=4'b0001 in cycle 1; wb_en in cycle 3 with addr=7, data=0xBF800000; busy high in cycles 1-3.
2. Request op=3 with a 5-cycle model; unit 2 drives a stray c_valid during WAIT -> stray ignored; writeback in cycle 7 with unit 3's data.
3. Request op=5 with NUM_UNITS=4 -> illegal_op pulse in cycle 1; busy, unit_a_valid and wb_en all stay 0.
4. Back-to-back: a second req_valid held during busy -> accepted in the first cycle busy=0; exactly two wb_en pulses, in order.
5. Reset asserted during WAIT, then c_valid arrives after reset release -> no wb_en; all outputs 0; IDLE accepts the next request normally.
6. With FPU_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, a unit that never responds -> timeout_err pulses 8 cycles after WAIT entry; no wb_en; busy falls the next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FPU dispatch block
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_e;

  localparam int FPR_ADDR_W = 5;
  localparam int FP_W       = 32;

  localparam int UNIT_NEG = 0;
  localparam int UNIT_ABS = 1;
  localparam int UNIT_ADD = 2;
  localparam int UNIT_MUL = 3;

endpackage

// File: rtl/fpu_dispatch_timer.sv
// rtl/fpu_dispatch_timer.sv - WAIT-state watchdog counter for fpu_dispatch
module fpu_dispatch_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th WAIT cycle; the FSM leaves WAIT on that edge.
  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_dispatch.sv
// rtl/fpu_dispatch.sv - issues one FPU instruction to a valid-only unit and writes the result back
// Optional WAIT watchdog enabled by FPU_DISPATCH_TIMEOUT_EN.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int OP_W           = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        req_valid,
  input  logic [OP_W-1:0]             req_op,
  input  logic [FP_W-1:0]             req_a,
  input  logic [FP_W-1:0]             req_b,
  input  logic [FPR_ADDR_W-1:0]       req_rd,
  output logic                        busy,
  output logic [FP_W-1:0]             unit_a_data,
  output logic [FP_W-1:0]             unit_b_data,
  output logic [NUM_UNITS-1:0]        unit_a_valid,
  input  logic [FP_W*NUM_UNITS-1:0]   unit_c_data,
  input  logic [NUM_UNITS-1:0]        unit_c_valid,
  output logic                        wb_en,
  output logic [FPR_ADDR_W-1:0]       wb_addr,
  output logic [FP_W-1:0]             wb_data,
  output logic                        illegal_op,
  output logic                        timeout_err
);

  state_e state_q, state_d;

  logic [OP_W-1:0]       op_q, op_d;
  logic [FPR_ADDR_W-1:0] rd_q, rd_d;
  logic [FP_W-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  busy_q, busy_d;
  logic [NUM_UNITS-1:0]  a_valid_q, a_valid_d;
  logic                  wb_en_q, wb_en_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;

  logic                  req_legal;
  logic                  sel_c_valid;
  logic [FP_W-1:0]       sel_c_data;
  logic                  timer_expired;

  assign req_legal = 32'(req_op) < 32'(NUM_UNITS);

  always_comb begin
    sel_c_valid = 1'b0;
    sel_c_data  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (op_q == OP_W'(i)) begin
        sel_c_valid = unit_c_valid[i];
        sel_c_data  = unit_c_data[FP_W*i +: FP_W];
      end
    end
  end

`ifdef FPU_DISPATCH_TIMEOUT_EN
  fpu_dispatch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .clr_i    (state_q == ISSUE),
    .en_i     (state_q == WAIT),
    .expired_o(timer_expired)
  );
`else
  assign timer_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_legal) begin
          op_d    = req_op;
          rd_d    = req_rd;
          a_d     = req_a;
          b_d     = req_b;
          state_d = ISSUE;
        end
      end
      // A response in the ISSUE cycle is stale and is deliberately not looked at.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sel_c_valid) begin
          res_d   = sel_c_data;
          state_d = WB;
        end else if (timer_expired) begin
          state_d = IDLE;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    busy_d    = (state_d != IDLE);
    a_valid_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (state_d == ISSUE && op_d == OP_W'(i)) begin
        a_valid_d[i] = 1'b1;
      end
    end
    wb_en_d   = (state_d == WB);
    illegal_d = (state_q == IDLE) && req_valid && !req_legal;
    timeout_d = (state_q == WAIT) && !sel_c_valid && timer_expired;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      a_valid_q <= '0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      a_valid_q <= a_valid_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy         = busy_q;
  assign unit_a_data  = a_q;
  assign unit_b_data  = b_q;
  assign unit_a_valid = a_valid_q;
  assign wb_en        = wb_en_q;
  assign wb_addr      = rd_q;
  assign wb_data      = res_q;
  assign illegal_op   = illegal_q;
  assign timeout_err  = timeout_q;

endmodule
